// File: rtl/wishbone_stream_bridge.sv
// Wishbone slave that lets the management core feed the accelerator input stream
// through an input FIFO and collect its results from an output FIFO.
module wishbone_stream_bridge #(
    parameter int          DATA_W    = 16,
    parameter int          IN_DEPTH  = 8,
    parameter int          OUT_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              acc_in_vld,
    input  logic              acc_in_rdy,
    output logic [DATA_W-1:0] acc_in_data,
    input  logic              acc_out_vld,
    output logic              acc_out_rdy,
    input  logic [DATA_W-1:0] acc_out_data
);
    localparam int IN_PW  = $clog2(IN_DEPTH);
    localparam int OUT_PW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    localparam logic [IN_PW-1:0]  IN_PTR_ONE   = IN_PW'(1);
    localparam logic [OUT_PW-1:0] OUT_PTR_ONE  = OUT_PW'(1);
    localparam logic [IN_CW-1:0]  IN_CNT_ONE   = IN_CW'(1);
    localparam logic [OUT_CW-1:0] OUT_CNT_ONE  = OUT_CW'(1);
    localparam logic [IN_CW-1:0]  IN_CNT_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_CNT_FULL = OUT_CW'(OUT_DEPTH);

    logic [DATA_W-1:0] r_in_mem  [IN_DEPTH];
    logic [DATA_W-1:0] r_out_mem [OUT_DEPTH];
    logic [IN_PW-1:0]  r_in_wp, r_in_rp;
    logic [OUT_PW-1:0] r_out_wp, r_out_rp;
    logic [IN_CW-1:0]  r_in_cnt;
    logic [OUT_CW-1:0] r_out_cnt;
    logic              r_ovf, r_udf, r_ack;
    logic [31:0]       r_dat;

    logic        w_hit, w_in_wr, w_out_rd, w_ctrl_wr, w_flush, w_clear;
    logic        w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic        w_in_hs, w_in_push, w_in_pop, w_out_push, w_out_pop;
    logic        w_ovf_set, w_udf_set;
    logic [1:0]  w_off;
    logic [7:0]  w_in_cnt8, w_out_cnt8;
    logic [31:0] w_status, w_rd_data;
    logic [DATA_W-1:0] w_out_head;
    logic        w_unused;

    assign w_unused = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    assign w_off     = wbs_adr_i[3:2];
    assign w_hit     = wbs_stb_i & wbs_cyc_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_in_wr   = w_hit & wbs_we_i & (w_off == 2'd1);
    assign w_out_rd  = w_hit & ~wbs_we_i & (w_off == 2'd2);
    assign w_ctrl_wr = w_hit & wbs_we_i & (w_off == 2'd3);
    assign w_flush   = w_ctrl_wr & wbs_dat_i[1];
    assign w_clear   = w_ctrl_wr & wbs_dat_i[0];

    assign w_in_full   = (r_in_cnt == IN_CNT_FULL);
    assign w_in_empty  = (r_in_cnt == {IN_CW{1'b0}});
    assign w_out_full  = (r_out_cnt == OUT_CNT_FULL);
    assign w_out_empty = (r_out_cnt == {OUT_CW{1'b0}});

    // A full input FIFO still accepts a write when the accelerator drains it the same cycle.
    assign w_in_hs    = ~w_in_empty & acc_in_rdy;
    assign w_in_pop   = w_in_hs & ~w_flush;
    assign w_in_push  = w_in_wr & (~w_in_full | w_in_hs) & ~w_flush;
    assign w_ovf_set  = w_in_wr & w_in_full & ~w_in_hs;
    assign w_out_push = acc_out_vld & ~w_out_full & ~w_flush;
    assign w_out_pop  = w_out_rd & ~w_out_empty & ~w_flush;
    assign w_udf_set  = w_out_rd & w_out_empty;

    assign w_in_cnt8  = 8'(r_in_cnt);
    assign w_out_cnt8 = 8'(r_out_cnt);
    assign w_out_head = r_out_mem[r_out_rp];
    assign w_status   = {8'h00, w_out_cnt8, w_in_cnt8, 2'b00, r_udf, r_ovf,
                         w_out_empty, w_out_full, w_in_empty, w_in_full};

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign acc_in_vld  = ~w_in_empty;
    assign acc_in_data = r_in_mem[r_in_rp];
    assign acc_out_rdy = ~w_out_full;

    // Read data selection by register offset
    always_comb begin
        w_rd_data = 32'h0000_0000;
        case (w_off)
            2'd0:    w_rd_data = w_status;
            2'd2:    w_rd_data = w_out_empty ? 32'h0000_0000 : 32'(w_out_head);
            default: w_rd_data = 32'h0000_0000;
        endcase
    end

    // Wishbone acknowledge and read data register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0000_0000;
        end else begin
            r_ack <= w_hit;
            if (w_hit & ~wbs_we_i) begin
                r_dat <= w_rd_data;
            end
        end
    end

    // Sticky status bits; a set event wins over a same-cycle clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~w_clear) | w_ovf_set;
            r_udf <= (r_udf & ~w_clear) | w_udf_set;
        end
    end

    // Input FIFO pointers and occupancy
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_flush) begin
            r_in_wp  <= {IN_PW{1'b0}};
            r_in_rp  <= {IN_PW{1'b0}};
            r_in_cnt <= {IN_CW{1'b0}};
        end else begin
            if (w_in_push) r_in_wp <= r_in_wp + IN_PTR_ONE;
            if (w_in_pop)  r_in_rp <= r_in_rp + IN_PTR_ONE;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + IN_CNT_ONE;
                2'b01:   r_in_cnt <= r_in_cnt - IN_CNT_ONE;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_flush) begin
            r_out_wp  <= {OUT_PW{1'b0}};
            r_out_rp  <= {OUT_PW{1'b0}};
            r_out_cnt <= {OUT_CW{1'b0}};
        end else begin
            if (w_out_push) r_out_wp <= r_out_wp + OUT_PTR_ONE;
            if (w_out_pop)  r_out_rp <= r_out_rp + OUT_PTR_ONE;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + OUT_CNT_ONE;
                2'b01:   r_out_cnt <= r_out_cnt - OUT_CNT_ONE;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // FIFO storage; contents are not reset
    always_ff @(posedge wb_clk_i) begin
        if (w_in_push)  r_in_mem[r_in_wp]   <= wbs_dat_i[DATA_W-1:0];
        if (w_out_push) r_out_mem[r_out_wp] <= acc_out_data;
    end

endmodule

// File: tb/tb_wishbone_stream_bridge.sv
// Directed bench for wishbone_stream_bridge: a queue-based model is checked every
// cycle, and hand-computed register values pin the model.
module tb_wishbone_stream_bridge;
    localparam int          DATA_W    = 16;
    localparam int          IN_DEPTH  = 8;
    localparam int          OUT_DEPTH = 8;
    localparam logic [31:0] BASE      = 32'h3000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [3:0]        sel;
    logic [31:0]       dat_i, adr;
    logic              ack;
    logic [31:0]       dat_o;
    logic              in_vld, in_rdy, out_vld, out_rdy;
    logic [DATA_W-1:0] in_data, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wishbone_stream_bridge #(
        .DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .acc_in_vld(in_vld), .acc_in_rdy(in_rdy), .acc_in_data(in_data),
        .acc_out_vld(out_vld), .acc_out_rdy(out_rdy), .acc_out_data(out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFOs as queues, registers as plain variables
    logic [DATA_W-1:0] in_q[$];
    logic [DATA_W-1:0] out_q[$];
    bit          m_valid = 1'b0;
    bit          m_ack, m_ovf, m_udf;
    logic [31:0] m_dat;

    always @(posedge clk) begin
        bit          hit, in_pop, out_push, set_o, set_u;
        logic [1:0]  off;
        logic [31:0] status;
        if (rst) begin
            in_q.delete(); out_q.delete();
            m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dat = 32'h0;
            m_valid = 1'b1;
        end else begin
            hit      = stb && cyc && !m_ack && (adr[31:4] == BASE[31:4]);
            off      = adr[3:2];
            in_pop   = (in_q.size() > 0) && in_rdy;
            out_push = out_vld && (out_q.size() < OUT_DEPTH);
            set_o    = 1'b0;
            set_u    = 1'b0;
            status   = {8'h00, 8'(out_q.size()), 8'(in_q.size()), 2'b00, m_udf, m_ovf,
                        out_q.size() == 0, out_q.size() == OUT_DEPTH,
                        in_q.size() == 0, in_q.size() == IN_DEPTH};
            if (hit && !we) begin
                if (off == 2'd0) m_dat = status;
                else if (off == 2'd2) begin
                    if (out_q.size() > 0) m_dat = 32'(out_q.pop_front());
                    else begin m_dat = 32'h0; set_u = 1'b1; end
                end else m_dat = 32'h0;
            end
            if (hit && we && off == 2'd3 && dat_i[1]) begin
                in_q.delete(); out_q.delete();
            end else begin
                if (in_pop) void'(in_q.pop_front());
                if (hit && we && off == 2'd1) begin
                    if (in_q.size() < IN_DEPTH) in_q.push_back(dat_i[DATA_W-1:0]);
                    else set_o = 1'b1;
                end
                if (out_push) out_q.push_back(out_data);
            end
            if (hit && we && off == 2'd3 && dat_i[0]) begin
                m_ovf = 1'b0; m_udf = 1'b0;
            end
            if (set_o) m_ovf = 1'b1;
            if (set_u) m_udf = 1'b1;
            m_ack = hit;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("dat_o", dat_o, m_dat);
            chk("in_vld", 32'(in_vld), 32'(in_q.size() != 0));
            if (in_q.size() != 0) chk("in_data", 32'(in_data), 32'(in_q[0]));
            chk("out_rdy", 32'(out_rdy), 32'(out_q.size() < OUT_DEPTH));
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        lat = 0;
        rd  = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        if (!ack) chk("ack_timeout", 32'(ack), 32'h1);
        rd  = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, a, d, rd, lat);
    endtask

    task automatic wb_rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b0, a, 32'h0, rd, lat);
        chk(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        bit seen;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        dat_i = 32'h0; adr = 32'h0; in_rdy = 1'b0; out_vld = 1'b0; out_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        wb_xfer(1'b0, BASE + 32'h0, 32'h0, rd, lat);
        chk("reset_status", rd, 32'h0000_000A);
        chk("ack_latency", 32'(lat), 32'd1);

        // Two input words, then drain in order
        wb_wr(BASE + 32'h4, 32'h0000_1234);
        wb_wr(BASE + 32'h4, 32'hFFFF_ABCD);
        wb_rd_chk("status_in2", BASE, 32'h0000_0208);
        in_rdy = 1'b1;
        @(negedge clk); chk("drain_w0", 32'(in_data), 32'h1234);
        @(negedge clk); chk("drain_w1", 32'(in_data), 32'hABCD);
        @(negedge clk); chk("drain_vld", 32'(in_vld), 32'h0);
        in_rdy = 1'b0;

        // Overflow with nine writes into eight entries
        for (int i = 0; i < 9; i++) wb_wr(BASE + 32'h4, 32'h100 + i);
        wb_rd_chk("status_ovf", BASE, 32'h0000_0819);
        in_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("ovf_drain", 32'(in_data), 32'h100 + i);
        end
        @(negedge clk); chk("ovf_no9th", 32'(in_vld), 32'h0);
        in_rdy = 1'b0;
        wb_rd_chk("status_ovf_held", BASE, 32'h0000_001A);
        wb_wr(BASE + 32'hC, 32'h1);
        wb_rd_chk("status_ovf_clr", BASE, 32'h0000_000A);

        // Output FIFO reads and underflow
        out_vld = 1'b1; out_data = 16'h0055;
        @(posedge clk); #1 out_data = 16'h00AA;
        @(posedge clk); #1 out_vld = 1'b0;
        wb_rd_chk("status_out2", BASE, 32'h0002_0002);
        wb_rd_chk("out_rd0", BASE + 32'h8, 32'h0000_0055);
        wb_rd_chk("out_rd1", BASE + 32'h8, 32'h0000_00AA);
        wb_rd_chk("out_rd_empty", BASE + 32'h8, 32'h0000_0000);
        wb_rd_chk("status_udf", BASE, 32'h0000_002A);
        wb_wr(BASE + 32'hC, 32'h1);

        // Fill output FIFO, then one read reopens it
        out_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_data = 16'h10 + 16'(i);
            @(posedge clk); #1;
        end
        out_vld = 1'b0;
        chk("out_full_rdy", 32'(out_rdy), 32'h0);
        wb_rd_chk("status_out_full", BASE, 32'h0008_0006);
        wb_rd_chk("out_full_rd", BASE + 32'h8, 32'h0000_0010);
        chk("out_rdy_after_pop", 32'(out_rdy), 32'h1);

        // Flush beats same-cycle handshakes on both FIFOs
        wb_wr(BASE + 32'h4, 32'h31);
        wb_wr(BASE + 32'h4, 32'h32);
        wb_rd_chk("status_pre_flush", BASE, 32'h0007_0200);
        in_rdy = 1'b1; out_vld = 1'b1; out_data = 16'h0099;
        wb_wr(BASE + 32'hC, 32'h2);
        out_vld = 1'b0;
        chk("flush_in_vld", 32'(in_vld), 32'h0);
        chk("flush_out_rdy", 32'(out_rdy), 32'h1);
        in_rdy = 1'b0;
        wb_rd_chk("status_flushed", BASE, 32'h0000_000A);

        // Address outside the register block is never acknowledged
        seen = 1'b0;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("nohit_ack", 32'(seen), 32'h0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
